// File: rtl/clut_rle_pkg.sv
// clut_rle_pkg: constants and encoder state type shared by the CLUT7 RLE encoder and decoder
package clut_rle_pkg;
    localparam int         RLE_FLAG_BIT  = 7;
    localparam logic [7:0] RLE_COUNT_EOL = 8'd0;
    localparam logic [7:0] RLE_MAX_COUNT = 8'd255;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_ACCUM,
        ST_OUT_SINGLE,
        ST_OUT_CODE,
        ST_OUT_COUNT
    } enc_state_e;
endpackage

// File: rtl/rle_line_counter.sv
// rle_line_counter: reloadable down-counter flagging the last item of a line
module rle_line_counter #(
    parameter int           W      = 11,
    parameter logic [W-1:0] RELOAD = W'(384)
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);
    logic [W-1:0] cnt_q;

    // Counts remaining items; consuming the last one reloads for the next line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= RELOAD;
        else if (load_i || (dec_i && last_o)) cnt_q <= RELOAD;
        else if (dec_i) cnt_q <= cnt_q - W'(1);
    end

    assign last_o = cnt_q == W'(1);
endmodule

// File: rtl/clut_rle_encoder.sv
// clut_rle_encoder: packs 7-bit CLUT pixels into CD-i CLUT7 run-length bytes
module clut_rle_encoder
    import clut_rle_pkg::*;
#(
    parameter int LINE_PIXELS = 384,
    parameter int MIN_RUN     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] src_pixel_i,
    input  logic       src_write_i,
    output logic       src_strobe_o,
    output logic [7:0] dst_pixel_o,
    output logic       dst_write_o,
    input  logic       dst_strobe_i,
    input  logic       passthrough_i
);
    localparam logic [7:0] MIN_LEN = 8'(MIN_RUN);

    enc_state_e state_q;
    logic [6:0] run_pix_q, pend_pix_q;
    logic [7:0] run_len_q, dst_pixel_q;
    logic       pend_vld_q, eol_q, dst_write_q;

    logic       take, acc, same, nxt_pend, flush, line_last;
    logic [6:0] in_pix, nxt_pix;
    logic [7:0] nxt_len;

    assign in_pix   = src_pixel_i[6:0];
    assign take     = state_q == ST_EMPTY || state_q == ST_ACCUM;
    assign acc      = take && src_write_i && !passthrough_i;
    assign same     = state_q == ST_ACCUM && in_pix == run_pix_q && run_len_q != RLE_MAX_COUNT;
    assign nxt_pix  = state_q == ST_EMPTY ? in_pix : run_pix_q;
    assign nxt_len  = state_q == ST_EMPTY ? 8'd1 : run_len_q + {7'd0, same};
    assign nxt_pend = state_q == ST_ACCUM && !same;
    assign flush    = line_last || nxt_pend;

    assign src_strobe_o = passthrough_i ? dst_strobe_i : take && src_write_i;
    assign dst_pixel_o  = passthrough_i ? src_pixel_i : dst_pixel_q;
    assign dst_write_o  = passthrough_i ? src_write_i : dst_write_q;

    rle_line_counter #(.W(11), .RELOAD(11'(LINE_PIXELS))) u_line (
        .clk    (clk),
        .reset  (reset),
        .load_i (passthrough_i),
        .dec_i  (acc),
        .last_o (line_last)
    );

    // Run accumulation and byte emission; output bytes are loaded on the transition into each OUT state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            run_pix_q   <= '0;
            run_len_q   <= '0;
            pend_pix_q  <= '0;
            pend_vld_q  <= 1'b0;
            eol_q       <= 1'b0;
            dst_pixel_q <= '0;
            dst_write_q <= 1'b0;
        end else if (passthrough_i) begin
            state_q     <= ST_EMPTY;
            run_len_q   <= '0;
            pend_vld_q  <= 1'b0;
            eol_q       <= 1'b0;
            dst_write_q <= 1'b0;
        end else if (acc) begin
            run_pix_q <= nxt_pix;
            run_len_q <= nxt_len;
            if (nxt_pend) begin
                pend_pix_q <= in_pix;
                pend_vld_q <= 1'b1;
            end
            if (line_last) eol_q <= 1'b1;
            if (flush) begin
                state_q     <= nxt_len < MIN_LEN ? ST_OUT_SINGLE : ST_OUT_CODE;
                dst_pixel_q <= {nxt_len >= MIN_LEN, nxt_pix};
                dst_write_q <= 1'b1;
            end else begin
                state_q <= ST_ACCUM;
            end
        end else if (dst_write_q && dst_strobe_i) begin
            if (state_q == ST_OUT_CODE) begin
                state_q     <= ST_OUT_COUNT;
                dst_pixel_q <= eol_q && !pend_vld_q ? RLE_COUNT_EOL : run_len_q;
            end else if (state_q == ST_OUT_SINGLE && run_len_q != 8'd1) begin
                run_len_q <= run_len_q - 8'd1;
            end else if (pend_vld_q) begin
                // A pending pixel that closed the line goes straight out as a single.
                run_pix_q   <= pend_pix_q;
                run_len_q   <= 8'd1;
                pend_vld_q  <= 1'b0;
                state_q     <= eol_q ? ST_OUT_SINGLE : ST_ACCUM;
                dst_pixel_q <= {1'b0, pend_pix_q};
                dst_write_q <= eol_q;
            end else begin
                state_q     <= ST_EMPTY;
                run_len_q   <= '0;
                eol_q       <= 1'b0;
                dst_write_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clut_rle_encoder.sv
// tb_clut_rle_encoder: directed and random line streams checked against a line-level RLE model
module tb_clut_rle_encoder;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sp [2];
    logic       sw [2];
    logic       ss [2];
    logic [7:0] dp [2];
    logic       dw [2];
    logic       ds [2];
    logic       pt [2];
    logic       ds_man [2];
    int         ds_mode [2];
    logic       hold_v [2];
    logic [8:0] hold_val [2];
    logic [7:0] exp0 [$], exp1 [$], got0 [$], got1 [$];
    logic [6:0] ln [$];
    int         n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    clut_rle_encoder #(.LINE_PIXELS(8)) u8 (
        .clk(clk), .reset(reset),
        .src_pixel_i(sp[0]), .src_write_i(sw[0]), .src_strobe_o(ss[0]),
        .dst_pixel_o(dp[0]), .dst_write_o(dw[0]), .dst_strobe_i(ds[0]),
        .passthrough_i(pt[0])
    );

    clut_rle_encoder #(.LINE_PIXELS(384)) u384 (
        .clk(clk), .reset(reset),
        .src_pixel_i(sp[1]), .src_write_i(sw[1]), .src_strobe_o(ss[1]),
        .dst_pixel_o(dp[1]), .dst_write_o(dw[1]), .dst_strobe_i(ds[1]),
        .passthrough_i(pt[1])
    );

    function automatic void check(input int s, input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s (dut %0d): got %0h, want %0h", nm, s, act, want);
        end
    endfunction

    function automatic void timeout(input int s, input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (dut %0d): got no progress, want handshake within budget", nm, s);
    endfunction

    function automatic void push_exp(input int s, input logic [7:0] b);
        if (s == 0) exp0.push_back(b); else exp1.push_back(b);
    endfunction

    function automatic int exp_size(input int s);
        return s == 0 ? exp0.size() : exp1.size();
    endfunction

    function automatic logic [7:0] pop_exp(input int s);
        if (s == 0) return exp0.pop_front();
        return exp1.pop_front();
    endfunction

    function automatic void push_got(input int s, input logic [7:0] b);
        if (s == 0) got0.push_back(b); else got1.push_back(b);
    endfunction

    function automatic int got_size(input int s);
        return s == 0 ? got0.size() : got1.size();
    endfunction

    function automatic logic [7:0] got_at(input int s, input int k);
        if (s == 0) return k < got0.size() ? got0[k] : 8'hxx;
        return k < got1.size() ? got1[k] : 8'hxx;
    endfunction

    function automatic void add(input logic [6:0] p, input int n);
        repeat (n) ln.push_back(p);
    endfunction

    // Line-level model: split equal groups greedily into chunks of at most 255;
    // short chunks become singles, a chunk reaching the end of the line uses count 0.
    function automatic void expect_line(input int s, input logic [6:0] px [$]);
        int i, n;
        i = 0;
        while (i < px.size()) begin
            n = 1;
            while (i + n < px.size() && px[i + n] == px[i] && n < 255) n++;
            if (n < 3) begin
                for (int k = 0; k < n; k++) push_exp(s, {1'b0, px[i]});
            end else begin
                push_exp(s, {1'b1, px[i]});
                push_exp(s, i + n == px.size() ? 8'd0 : 8'(n));
            end
            i += n;
        end
    endfunction

    always @(posedge clk) begin
        #2;
        for (int s = 0; s < 2; s++)
            ds[s] = ds_mode[s] == 0 ? 1'b1 : ds_mode[s] == 1 ? 1'($urandom_range(0, 1)) : ds_man[s];
    end

    // Per-cycle compare: handshake rules, stall stability, and every output byte against the model.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (reset || pt[s]) begin
                hold_v[s] = 1'b0;
            end else begin
                if (hold_v[s]) check(s, "stall_hold", 32'({dw[s], dp[s]}), 32'(hold_val[s]));
                if (dw[s]) check(s, "src_strobe_in_out", 32'(ss[s]), 32'd0);
                else check(s, "src_strobe", 32'(ss[s]), 32'(sw[s]));
                if (dw[s] && ds[s]) begin
                    if (exp_size(s) == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL extra_byte (dut %0d): got %0h, want no byte", s, dp[s]);
                    end else begin
                        check(s, "byte", 32'(dp[s]), 32'(pop_exp(s)));
                    end
                    push_got(s, dp[s]);
                end
                hold_v[s]   = dw[s] && !ds[s];
                hold_val[s] = {dw[s], dp[s]};
            end
        end
    end

    task automatic send(input int s, input logic [6:0] p);
        int t;
        t = 0;
        sp[s] = {1'($urandom_range(0, 1)), p};
        sw[s] = 1'b1;
        @(negedge clk);
        while (!ss[s] && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 2000) timeout(s, "send");
        @(posedge clk);
        #1;
        sw[s] = 1'b0;
    endtask

    task automatic send_line(input int s, input bit gaps);
        expect_line(s, ln);
        foreach (ln[i]) begin
            send(s, ln[i]);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        ln = {};
    endtask

    task automatic drain(input int s);
        int t;
        t = 0;
        while ((exp_size(s) != 0 || dw[s]) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) timeout(s, "drain");
    endtask

    task automatic check_seq(input int s, input string nm, input int n, input logic [63:0] lit);
        drain(s);
        check(s, {nm, "_len"}, 32'(got_size(s)), 32'(n));
        for (int k = 0; k < n; k++) check(s, nm, 32'(got_at(s, k)), 32'(lit[(n - 1 - k) * 8 +: 8]));
        if (s == 0) got0 = {}; else got1 = {};
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            sp[s] = '0; sw[s] = 1'b0; pt[s] = 1'b0; ds_man[s] = 1'b0; ds_mode[s] = 2; hold_v[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check(s, "rst_dst_write", 32'(dw[s]), 32'd0);
            check(s, "rst_dst_pixel", 32'(dp[s]), 32'd0);
            check(s, "rst_src_strobe", 32'(ss[s]), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sw[s] = 1'b1;
            #1;
            check(s, "empty_src_strobe", 32'(ss[s]), 32'd1);
            sw[s] = 1'b0;
        end
        @(posedge clk);
        #1;
        ds_mode[0] = 0;
        ds_mode[1] = 0;

        add(7'h05, 4); add(7'h09, 2); add(7'h03, 2);
        send_line(0, 0);
        check_seq(0, "t1", 6, 64'h85_04_09_09_03_03);
        add(7'h01, 1); add(7'h02, 1); add(7'h07, 6);
        send_line(0, 0);
        check_seq(0, "t2", 4, 64'h01_02_87_00);
        add(7'h0A, 8);
        send_line(0, 1);
        check_seq(0, "full_line", 2, 64'h8A_00);
        add(7'h04, 3); add(7'h01, 1); add(7'h02, 1); add(7'h01, 1); add(7'h02, 1); add(7'h01, 1);
        send_line(0, 0);
        check_seq(0, "min_run", 7, 64'h84_03_01_02_01_02_01);
        add(7'h01, 5); add(7'h02, 3);
        send_line(0, 0);
        check_seq(0, "eol_min_run", 4, 64'h81_05_82_00);

        ds_mode[0] = 2;
        ds_man[0] = 1'b0;
        add(7'h05, 4); add(7'h09, 2); add(7'h03, 2);
        expect_line(0, ln);
        ln = {};
        repeat (4) send(0, 7'h05);
        send(0, 7'h09);
        repeat (10) begin
            @(negedge clk);
            check(0, "stall_src_strobe", 32'(ss[0]), 32'd0);
            check(0, "stall_pixel", 32'({dw[0], dp[0]}), 32'h185);
        end
        @(posedge clk);
        #1;
        ds_mode[0] = 0;
        send(0, 7'h09); send(0, 7'h03); send(0, 7'h03);
        check_seq(0, "stall", 6, 64'h85_04_09_09_03_03);

        ds_mode[0] = 1;
        repeat (20) begin
            for (int i = 0; i < 8; i++) ln.push_back(7'($urandom_range(0, 2)));
            send_line(0, 1);
        end
        drain(0);
        got0 = {};

        ds_mode[0] = 2;
        ds_man[0] = 1'b1;
        repeat (3) send(0, 7'h01);
        pt[0] = 1'b1;
        sp[0] = 8'h8A;
        sw[0] = 1'b1;
        @(posedge clk);
        #3;
        check(0, "pt_pixel_8a", 32'(dp[0]), 32'h8A);
        check(0, "pt_write", 32'(dw[0]), 32'd1);
        check(0, "pt_strobe_hi", 32'(ss[0]), 32'd1);
        ds_man[0] = 1'b0;
        @(posedge clk);
        #3;
        check(0, "pt_strobe_lo", 32'(ss[0]), 32'd0);
        sp[0] = 8'h00;
        ds_man[0] = 1'b1;
        @(posedge clk);
        #3;
        check(0, "pt_pixel_00", 32'(dp[0]), 32'h00);
        check(0, "pt_strobe_hi2", 32'(ss[0]), 32'd1);
        sw[0] = 1'b0;
        #1;
        check(0, "pt_write_lo", 32'(dw[0]), 32'd0);
        @(posedge clk);
        #1;
        pt[0] = 1'b0;
        ds_mode[0] = 0;
        add(7'h01, 1); add(7'h02, 1); add(7'h07, 6);
        send_line(0, 0);
        check_seq(0, "after_pt", 4, 64'h01_02_87_00);

        ds_mode[0] = 2;
        ds_man[0] = 1'b0;
        push_exp(0, 8'h85);
        repeat (4) send(0, 7'h05);
        send(0, 7'h09);
        ds_man[0] = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ds_man[0] = 1'b0;
        @(posedge clk);
        #1;
        check(0, "rst_mid_write", 32'(dw[0]), 32'd0);
        check(0, "rst_mid_pixel", 32'(dp[0]), 32'd0);
        check(0, "rst_code_sent", 32'(exp_size(0)), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        ds_mode[0] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_seq(0, "rst_abort", 1, 64'h85);
        add(7'h05, 4); add(7'h09, 2); add(7'h03, 2);
        send_line(0, 0);
        check_seq(0, "after_rst", 6, 64'h85_04_09_09_03_03);

        add(7'h11, 384);
        send_line(1, 0);
        check_seq(1, "line_384", 4, 64'h91_FF_91_00);
        add(7'h01, 128); add(7'h02, 256);
        send_line(1, 0);
        check_seq(1, "max_at_eol", 5, 64'h81_80_82_FF_02);
        add(7'h01, 129); add(7'h02, 255);
        send_line(1, 1);
        check_seq(1, "exact_255_eol", 4, 64'h81_81_82_00);
        ds_mode[1] = 1;
        for (int i = 0; i < 384; i++) ln.push_back(7'((i / 5) % 3));
        send_line(1, 1);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/clut_rle_encoder.md
# clut_rle_encoder

Compresses a stream of 7-bit CLUT pixels into the CD-i CLUT7 run-length format consumed by `clut_rle`. It sits between a pixel producer (test pattern generator, frame-capture path, or bench model) and any `pixelstream` sink that expects RLE7 bytes. It tracks line boundaries so that runs reaching the end of a line use the count-0 "to end of line" code.

## Interface
- `LINE_PIXELS`, 384: pixels per line; the line counter reloads to this value.
- `MIN_RUN`, 3: shortest run encoded as code plus count; shorter runs are emitted as singles.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `src`  pixelstream.sink  -  input pixels: `pixel[6:0]` is used and `pixel[7]` is ignored; `write` is valid; `strobe` is the accept from this block.
- `dst`  pixelstream.source  -  output RLE7 bytes: `pixel[7:0]`, `write` is valid, `strobe` is the accept from downstream.
- `passthrough`  in  1  when 1, `dst.pixel=src.pixel`, `dst.write=src.write` and `src.strobe=dst.strobe`, all combinationally.

## Operation
- A transfer occurs when `write && strobe` in the same cycle, on both ports.
- Output byte format:
  - Single pixel: `{0,p}`.
  - Run: `{1,p}` followed by a count byte of 1..255.
  - Count byte 0 means repeat until end of line.
- Registers:
  - `run_pix[6:0]`
  - `run_len[7:0]`
  - `pend_pix[6:0]` and `pend_vld`
  - `eol` flag
  - `linecnt[10:0]`, counting remaining input pixels in the line; reloads to LINE_PIXELS when it reaches 0.
- States: EMPTY, ACCUM, OUT_SINGLE, OUT_CODE, OUT_COUNT.
- EMPTY:
  - `src.strobe=src.write`.
  - On accept, load `run_pix`, set `run_len=1` and go to ACCUM.
  - If this was the last pixel of the line, set `eol` and go straight to the flush instead.
- ACCUM:
  - `src.strobe=src.write`.
  - Accepted pixel equal to `run_pix` and `run_len<255`: increment `run_len`.
  - Accepted pixel different: store it in `pend_pix`, set `pend_vld`, then flush.
  - Accepted pixel equal with `run_len==255`: flush a count-255 run and hold the new pixel as pending.
  - Accepted pixel was the last of the line: include it in the run if equal (or hold it as pending if not), set `eol`, then flush.
- Flush:
  - `run_len<MIN_RUN`: go to OUT_SINGLE, which emits `run_len` copies of `{0,run_pix}`, one per `dst` transfer.
  - Otherwise: go to OUT_CODE, which emits `{1,run_pix}`, then OUT_COUNT.
  - OUT_COUNT emits 0 if `eol` is set and no pending pixel exists; otherwise it emits `run_len`.
- After flush:
  - If `pend_vld`: load the pending pixel as a run of length 1 and go to ACCUM.
  - A pending pixel that was itself the last of the line is flushed immediately as a single, with `eol` kept.
  - If no pending pixel: go to EMPTY and clear `eol`.
- `src.strobe=0` in all OUT_* states.
- `dst.write=1` only in OUT_* states.
- The block never drops, duplicates or reorders pixels. Decoding the output with `clut_rle` reproduces the input exactly.
- Asserting `passthrough` forces EMPTY, clears `pend_vld`, `eol` and `run_len`, and reloads `linecnt`.

## Timing
- Reset:
  - state EMPTY, `run_len=0`, `pend_vld=0`, `eol=0`, `linecnt=LINE_PIXELS`.
  - `dst.write=0`, `dst.pixel=0`.
  - `src.strobe` is combinational from `src.write` (1 if `src.write` in EMPTY).
- Latency: the first output byte of a run is valid the cycle after the accept that terminated the run.
- Throughput: at most one output byte per cycle; input is stalled during every flush.
- `dst.pixel` and `dst.write` are driven from registers only and are stable while `dst.strobe=0`.
- Reset asserted mid-flush aborts immediately. No partial byte pair is completed after reset is released.
- Simultaneous end of line and `run_len==255` with an equal pixel: emit `{1,p}`, 255, then `{0,p}` as the tail single. A count-0 code is not used.

## Structure
- Shared package `clut_rle_pkg`:
  - `RLE_FLAG_BIT=7`
  - `RLE_COUNT_EOL=8'd0`
  - `RLE_MAX_COUNT=8'd255`
  - encoder state enum
  - The decoder takes the same constants from this package.
- Sub-module `rle_line_counter`: reloadable down-counter with a `last` output, shared with the decoder's pixel counter.

## Test plan
- LINE_PIXELS=8, input 05,05,05,05,09,09,03,03 -> output 85,04,09,09,03,03.
- LINE_PIXELS=8, input 01,02,07×6 -> output 01,02,87,00.
- LINE_PIXELS=384, line of 384×11 -> output 91,FF,91,00; then the next line starts fresh.
- `dst.strobe` held low for 10 cycles mid-run -> `dst.pixel` and `dst.write` remain constant, `src.strobe=0`, no bytes lost.
- Reset pulse between emitting 85 and its count -> no count byte appears; the next line encodes from EMPTY.
- `passthrough=1`, input 8A,00 -> output 8A,00 in the same cycles; `src.strobe` follows `dst.strobe`.
